// File: rtl/pipe_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pipe_pkg : shared state type and default packed widths for elastic stages
// Rev 1.0
// ---------------------------------------------------------------------------
package pipe_pkg;

  typedef enum logic [1:0] {
    PS_EMPTY = 2'd0,
    PS_ONE   = 2'd1,
    PS_TWO   = 2'd2
  } pipe_state_t;

  localparam int RV_XLEN    = 32;
  localparam int VEC_W      = 128;
  localparam int RD_W       = 6;
  // ALU result bus ++ write data bus; instr word + rd + enables/selectors
  localparam int DEF_DATA_W = 2 * VEC_W;
  localparam int DEF_CTRL_W = RV_XLEN + RD_W + 10;

endpackage
`default_nettype wire

// File: rtl/pipe_sat_counter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pipe_sat_counter : saturating event counter with synchronous clear
// Rev 1.0
// ---------------------------------------------------------------------------
module pipe_sat_counter
  import pipe_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             async_reset,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] C_MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0] r_count;

  // clear takes precedence over a same-cycle increment
  always_ff @(posedge clock or negedge async_reset) begin
    if (!async_reset) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else if (inc && (r_count != C_MAX)) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/pipe_stage_elastic.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pipe_stage_elastic : valid/ready pipeline stage with 2-entry skid buffer,
//                      control-zeroing flush and saturating stall counter
// Rev 1.0
// ---------------------------------------------------------------------------
module pipe_stage_elastic
  import pipe_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int CTRL_W = DEF_CTRL_W,
  parameter int CNT_W  = 16
) (
  input  logic              clock,
  input  logic              async_reset,
  input  logic              sync_reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_count,
  input  logic              clr_stats
);

  pipe_state_t       r_state, w_state_nxt;
  logic              r_in_ready, w_in_ready_nxt;
  logic [CTRL_W-1:0] r_main_ctrl, r_skid_ctrl, w_main_ctrl_nxt, w_skid_ctrl_nxt;
  logic [DATA_W-1:0] r_main_data, r_skid_data, w_main_data_nxt, w_skid_data_nxt;
  logic              w_out_valid, w_push, w_pop;

  assign w_out_valid = (r_state != PS_EMPTY);
  assign w_push      = in_valid & r_in_ready;
  assign w_pop       = w_out_valid & out_ready;

  always_comb begin
    w_state_nxt     = r_state;
    w_main_ctrl_nxt = r_main_ctrl;
    w_main_data_nxt = r_main_data;
    w_skid_ctrl_nxt = r_skid_ctrl;
    w_skid_data_nxt = r_skid_data;
    if (!sync_reset) begin
      // flush drops any same-cycle push; data fields keep their last value
      w_state_nxt     = PS_EMPTY;
      w_main_ctrl_nxt = '0;
      w_skid_ctrl_nxt = '0;
    end else begin
      case (r_state)
        PS_EMPTY: begin
          if (w_push) begin
            w_state_nxt     = PS_ONE;
            w_main_ctrl_nxt = in_ctrl;
            w_main_data_nxt = in_data;
          end
        end
        PS_ONE: begin
          if (w_push && w_pop) begin
            w_main_ctrl_nxt = in_ctrl;
            w_main_data_nxt = in_data;
          end else if (w_push) begin
            w_state_nxt     = PS_TWO;
            w_skid_ctrl_nxt = in_ctrl;
            w_skid_data_nxt = in_data;
          end else if (w_pop) begin
            w_state_nxt     = PS_EMPTY;
            w_main_ctrl_nxt = '0;
          end
        end
        PS_TWO: begin
          if (w_pop) begin
            w_state_nxt     = PS_ONE;
            w_main_ctrl_nxt = r_skid_ctrl;
            w_main_data_nxt = r_skid_data;
            w_skid_ctrl_nxt = '0;
          end
        end
        default: begin
          w_state_nxt     = PS_EMPTY;
          w_main_ctrl_nxt = '0;
          w_skid_ctrl_nxt = '0;
        end
      endcase
    end
    w_in_ready_nxt = (w_state_nxt != PS_TWO);
  end

  always_ff @(posedge clock or negedge async_reset) begin
    if (!async_reset) begin
      r_state     <= PS_EMPTY;
      r_in_ready  <= 1'b0;
      r_main_ctrl <= '0;
      r_main_data <= '0;
      r_skid_ctrl <= '0;
      r_skid_data <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_in_ready  <= w_in_ready_nxt;
      r_main_ctrl <= w_main_ctrl_nxt;
      r_main_data <= w_main_data_nxt;
      r_skid_ctrl <= w_skid_ctrl_nxt;
      r_skid_data <= w_skid_data_nxt;
    end
  end

  pipe_sat_counter #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .clock       (clock),
    .async_reset (async_reset),
    .inc         (w_out_valid & ~out_ready),
    .clr         (clr_stats),
    .count       (stall_count)
  );

  assign in_ready  = r_in_ready;
  assign out_valid = w_out_valid;
  assign out_ctrl  = r_main_ctrl;
  assign out_data  = r_main_data;
  assign occupancy = r_state;

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_elastic.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_pipe_stage_elastic : queue-scoreboard bench for pipe_stage_elastic
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_pipe_stage_elastic;

  localparam int DW = 32;
  localparam int CW = 16;
  localparam int NW = 4;
  localparam int STALL_MAX = (1 << NW) - 1;

  typedef struct {
    logic [CW-1:0] ctrl;
    logic [DW-1:0] data;
  } item_t;

  logic          clock = 1'b0;
  logic          async_reset, sync_reset, in_valid, out_ready, clr_stats;
  logic [CW-1:0] in_ctrl;
  logic [DW-1:0] in_data;
  logic          in_ready, out_valid;
  logic [CW-1:0] out_ctrl;
  logic [DW-1:0] out_data;
  logic [1:0]    occupancy;
  logic [NW-1:0] stall_count;

  int checks = 0;
  int failures = 0;

  // reference model: in-flight items, registered acceptance, stall events, last main data
  item_t         q[$];
  logic          m_ready = 1'b0;
  int            m_stall = 0;
  logic [DW-1:0] last_data = '0;
  int            n_pop = 0;

  pipe_stage_elastic #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(NW)) dut (
    .clock       (clock),
    .async_reset (async_reset),
    .sync_reset  (sync_reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_ctrl     (in_ctrl),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_ctrl    (out_ctrl),
    .out_data    (out_data),
    .occupancy   (occupancy),
    .stall_count (stall_count),
    .clr_stats   (clr_stats)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // issue side: record accepted transfers at the clock edge
  initial forever begin
    @(posedge clock);
    if (!async_reset) begin
      q.delete();
      m_ready = 1'b0;
    end else if (!sync_reset) begin
      q.delete();
      m_ready = 1'b1;
    end else begin
      if (in_valid && m_ready) q.push_back('{ctrl: in_ctrl, data: in_data});
      m_ready = (q.size() < 2);
    end
  end

  // monitor side: compare presented outputs mid-cycle, then retire handshakes
  initial forever begin
    @(negedge clock);
    if (!async_reset) begin
      m_stall   = 0;
      last_data = '0;
    end else begin
      chk("in_ready", in_ready, m_ready);
      chk("occupancy", occupancy, q.size());
      chk("out_valid", out_valid, q.size() != 0);
      chk("stall_count", stall_count, m_stall);
      if (q.size() != 0) begin
        chk("out_ctrl", out_ctrl, q[0].ctrl);
        chk("out_data", out_data, q[0].data);
        last_data = q[0].data;
      end else begin
        chk("bubble_ctrl", out_ctrl, 0);
        chk("bubble_data_hold", out_data, last_data);
      end
      if (clr_stats) m_stall = 0;
      else if (q.size() != 0 && !out_ready && m_stall < STALL_MAX) m_stall++;
      if (q.size() != 0 && out_ready) begin
        void'(q.pop_front());
        n_pop++;
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic v, input logic [CW-1:0] c, input logic [DW-1:0] d);
    in_valid = v;
    in_ctrl  = c;
    in_data  = d;
  endtask

  // present one item and hold it until the stage accepts it (bounded)
  task automatic send(input logic [CW-1:0] c, input logic [DW-1:0] d);
    drive(1'b1, c, d);
    for (int k = 0; k < 20 && !in_ready; k++) step();
    chk("send_ready", in_ready, 1);
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    int base;
    async_reset = 1'b0;
    sync_reset  = 1'b1;
    out_ready   = 1'b0;
    clr_stats   = 1'b0;
    drive(1'b0, '0, '0);
    repeat (2) step();
    async_reset = 1'b1;
    repeat (2) step();

    // streaming at full rate
    out_ready = 1'b1;
    base = n_pop;
    for (int i = 1; i <= 100; i++) begin
      drive(1'b1, CW'(16'hC000 | i), DW'(i));
      step();
    end
    in_valid = 1'b0;
    repeat (3) step();
    chk("stream_count", n_pop - base, 100);

    // backpressure: A, B fill the stage, C retried
    out_ready = 1'b0;
    base = n_pop;
    send(16'h0A0A, 32'hAAAA_0001);
    send(16'h0B0B, 32'hBBBB_0002);
    chk("bp_occ_two", occupancy, 2);
    chk("bp_in_ready_low", in_ready, 0);
    drive(1'b1, 16'h0C0C, 32'hCCCC_0003);
    repeat (3) step();
    chk("bp_occ_hold", occupancy, 2);
    out_ready = 1'b1;
    for (int k = 0; k < 20 && !in_ready; k++) step();
    chk("bp_c_ready", in_ready, 1);
    step();
    in_valid = 1'b0;
    repeat (4) step();
    chk("bp_count", n_pop - base, 3);

    // flush while holding two entries with a push attempt
    out_ready = 1'b0;
    send(16'h0D0D, 32'hDDDD_0004);
    send(16'h0E0E, 32'hEEEE_0005);
    sync_reset = 1'b0;
    drive(1'b1, 16'h0F0F, 32'hFFFF_0006);
    step();
    sync_reset = 1'b1;
    in_valid   = 1'b0;
    chk("flush2_valid", out_valid, 0);
    chk("flush2_ctrl", out_ctrl, 0);
    chk("flush2_occ", occupancy, 0);
    chk("flush2_data_hold", out_data, 32'hDDDD_0004);
    chk("flush2_in_ready", in_ready, 1);
    step();

    // flush in ONE with an accepted-looking push: push is lost
    send(16'h1111, 32'h1111_0007);
    sync_reset = 1'b0;
    drive(1'b1, 16'h2222, 32'h2222_0008);
    step();
    sync_reset = 1'b1;
    in_valid   = 1'b0;
    chk("flush1_occ", occupancy, 0);
    chk("flush1_data_hold", out_data, 32'h1111_0007);
    repeat (2) step();
    chk("flush1_still_empty", occupancy, 0);

    // stall counter saturation and clear
    clr_stats = 1'b1;
    step();
    clr_stats = 1'b0;
    send(16'h3333, 32'h3333_0009);
    repeat (20) step();
    chk("stall_sat", stall_count, STALL_MAX);
    clr_stats = 1'b1;
    step();
    clr_stats = 1'b0;
    chk("stall_clr", stall_count, 0);
    out_ready = 1'b1;
    repeat (3) step();

    // reset mid-stream with both entries occupied
    out_ready = 1'b0;
    send(16'h4444, 32'h4444_000A);
    send(16'h5555, 32'h5555_000B);
    repeat (2) step();
    async_reset = 1'b0;
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_ctrl", out_ctrl, 0);
    chk("rst_data", out_data, 0);
    chk("rst_occ", occupancy, 0);
    chk("rst_stall", stall_count, 0);
    chk("rst_in_ready", in_ready, 0);
    step();
    async_reset = 1'b1;
    step();
    chk("rst_release_ready", in_ready, 1);
    chk("rst_release_occ", occupancy, 0);

    // randomized traffic with occasional flush and stats clear
    for (int i = 0; i < 10000; i++) begin
      drive(1'($urandom_range(0, 1)), CW'($urandom), DW'($urandom));
      out_ready  = ($urandom_range(0, 3) != 0);
      sync_reset = ($urandom_range(0, 49) != 0);
      clr_stats  = ($urandom_range(0, 99) == 0);
      step();
    end
    in_valid   = 1'b0;
    sync_reset = 1'b1;
    clr_stats  = 1'b0;
    out_ready  = 1'b1;
    repeat (5) step();
    chk("drain_occ", occupancy, 0);
    chk("drain_valid", out_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
